// File: rtl/mmio_byte_master.sv
// mmio_byte_master: splits one CPU load/store (byte/half/word) into
// little-endian single-byte MMIO transactions and returns one response.
//
// Ports
//   i_clk, i_rst          clock, async active-low reset
//   i_req_valid/o_req_ready   request handshake (ready = idle)
//   i_req_addr/we/size/wdata  request payload (size 0=byte 1=half 2=word)
//   o_rsp_valid/rdata/err     one-cycle response pulse
//   o_mmio_addr/data_out      MMIO byte address and write byte
//   i_mmio_data_in            read byte, sampled at end of each read cycle
//   o_mmio_we/o_mmio_re       per-byte write/read strobes
module mmio_byte_master #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic                  i_req_we,
   input  logic [1:0]            i_req_size,
   input  logic [31:0]           i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [31:0]           o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic [ADDR_WIDTH-1:0] o_mmio_addr,
   output logic [7:0]            o_mmio_data_out,
   input  logic [7:0]            i_mmio_data_in,
   output logic                  o_mmio_we,
   output logic                  o_mmio_re
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]            state, state_d;
   logic [ADDR_WIDTH-1:0] addr_l, addr_l_d;
   logic                  we_l, we_l_d;
   logic [1:0]            size_l, size_l_d;
   logic [31:0]           wdata_l, wdata_l_d;
   logic [1:0]            k, k_d;
   logic [31:0]           acc, acc_d;

   logic [ADDR_WIDTH-1:0] mmio_addr_d;
   logic [7:0]            mmio_data_out_d;
   logic                  mmio_we_d, mmio_re_d;
   logic                  rsp_valid_d, rsp_err_d;
   logic [31:0]           rsp_rdata_d;

   logic                  illegal;
   logic [1:0]            last_k;
   logic [4:0]            sh_cur, sh_nxt;

   assign o_req_ready = (state == IDLE);

   // Misaligned half/word or reserved size is rejected without touching the bus.
   always_comb begin
      illegal = 1'b0;
      case (i_req_size)
         2'd1:    illegal = i_req_addr[0];
         2'd2:    illegal = (i_req_addr[1:0] != 2'b00);
         2'd3:    illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end

   // Index of the final byte: 0, 1 or 3 for byte/half/word.
   assign last_k = 2'((3'd1 << size_l) - 3'd1);
   assign sh_cur = {k, 3'b000};
   assign sh_nxt = {k + 2'd1, 3'b000};

   // Next-state and next-output logic.
   always_comb begin
      state_d         = state;
      addr_l_d        = addr_l;
      we_l_d          = we_l;
      size_l_d        = size_l;
      wdata_l_d       = wdata_l;
      k_d             = k;
      acc_d           = acc;
      mmio_addr_d     = o_mmio_addr;
      mmio_data_out_d = 8'h00;
      mmio_we_d       = 1'b0;
      mmio_re_d       = 1'b0;
      rsp_valid_d     = 1'b0;
      rsp_err_d       = 1'b0;
      rsp_rdata_d     = 32'h0;

      case (state)
         IDLE: begin
            if (i_req_valid) begin
               addr_l_d  = i_req_addr;
               we_l_d    = i_req_we;
               size_l_d  = i_req_size;
               wdata_l_d = i_req_wdata;
               k_d       = 2'd0;
               acc_d     = 32'h0;
               if (illegal) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d         = XFER;
                  mmio_addr_d     = i_req_addr;
                  mmio_we_d       = i_req_we;
                  mmio_re_d       = !i_req_we;
                  mmio_data_out_d = i_req_we ? i_req_wdata[7:0] : 8'h00;
               end
            end
         end
         XFER: begin
            // Read byte for the strobe currently on the bus.
            if (!we_l) begin
               acc_d[sh_cur +: 8] = i_mmio_data_in;
            end
            if (k == last_k) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_l ? 32'h0 : acc_d;
            end else begin
               k_d             = k + 2'd1;
               mmio_addr_d     = addr_l + ADDR_WIDTH'(k_d);
               mmio_we_d       = we_l;
               mmio_re_d       = !we_l;
               mmio_data_out_d = we_l ? wdata_l[sh_nxt +: 8] : 8'h00;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state           <= IDLE;
         addr_l          <= '0;
         we_l            <= 1'b0;
         size_l          <= 2'd0;
         wdata_l         <= 32'h0;
         k               <= 2'd0;
         acc             <= 32'h0;
         o_mmio_addr     <= '0;
         o_mmio_data_out <= 8'h00;
         o_mmio_we       <= 1'b0;
         o_mmio_re       <= 1'b0;
         o_rsp_valid     <= 1'b0;
         o_rsp_err       <= 1'b0;
         o_rsp_rdata     <= 32'h0;
      end else begin
         state           <= state_d;
         addr_l          <= addr_l_d;
         we_l            <= we_l_d;
         size_l          <= size_l_d;
         wdata_l         <= wdata_l_d;
         k               <= k_d;
         acc             <= acc_d;
         o_mmio_addr     <= mmio_addr_d;
         o_mmio_data_out <= mmio_data_out_d;
         o_mmio_we       <= mmio_we_d;
         o_mmio_re       <= mmio_re_d;
         o_rsp_valid     <= rsp_valid_d;
         o_rsp_err       <= rsp_err_d;
         o_rsp_rdata     <= rsp_rdata_d;
      end
   end

endmodule

// File: tb/tb_mmio_byte_master.sv
// tb_mmio_byte_master: directed bench for mmio_byte_master with a scoreboard
// of expected MMIO strobes and responses, checked by a negedge monitor.
module tb_mmio_byte_master;

   logic        i_clk;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_addr;
   logic        i_req_we;
   logic [1:0]  i_req_size;
   logic [31:0] i_req_wdata;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic [31:0] o_mmio_addr;
   logic [7:0]  o_mmio_data_out;
   logic [7:0]  i_mmio_data_in;
   logic        o_mmio_we;
   logic        o_mmio_re;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  data;
   } strobe_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   strobe_t     exp_strobes [$];
   rsp_t        exp_rsps [$];
   logic [7:0]  periph [16];
   int          checks = 0;
   int          errors = 0;

   mmio_byte_master #(.ADDR_WIDTH(32)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .i_req_addr      (i_req_addr),
      .i_req_we        (i_req_we),
      .i_req_size      (i_req_size),
      .i_req_wdata     (i_req_wdata),
      .o_rsp_valid     (o_rsp_valid),
      .o_rsp_rdata     (o_rsp_rdata),
      .o_rsp_err       (o_rsp_err),
      .o_mmio_addr     (o_mmio_addr),
      .o_mmio_data_out (o_mmio_data_out),
      .i_mmio_data_in  (i_mmio_data_in),
      .o_mmio_we       (o_mmio_we),
      .o_mmio_re       (o_mmio_re)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Combinational peripheral: read byte depends on current address.
   assign i_mmio_data_in = o_mmio_re ? periph[o_mmio_addr[3:0]] : 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: every strobe and every response must match the scoreboard.
   always @(negedge i_clk) begin
      if (o_mmio_we || o_mmio_re) begin
         check("we_re_exclusive", 32'(o_mmio_we && o_mmio_re), 32'd0);
         if (exp_strobes.size() == 0) begin
            check("unexpected_strobe", 32'(o_mmio_addr), 32'hFFFF_FFFF);
         end else begin
            strobe_t s;
            s = exp_strobes.pop_front();
            check("strobe_addr", o_mmio_addr, s.addr);
            check("strobe_we", 32'(o_mmio_we), 32'(s.we));
            check("strobe_data", 32'(o_mmio_data_out), 32'(s.data));
         end
      end
      if (o_rsp_valid) begin
         if (exp_rsps.size() == 0) begin
            check("unexpected_rsp", 32'(o_rsp_valid), 32'd0);
         end else begin
            rsp_t r;
            r = exp_rsps.pop_front();
            check("rsp_rdata", o_rsp_rdata, r.rdata);
            check("rsp_err", 32'(o_rsp_err), 32'(r.err));
         end
      end
   end

   task automatic push_strobes(input logic [31:0] a, input logic we, input int n,
                               input logic [31:0] wd);
      for (int i = 0; i < n; i++) begin
         strobe_t s;
         s.addr = a + 32'(i);
         s.we   = we;
         s.data = we ? wd[8*i +: 8] : 8'h00;
         exp_strobes.push_back(s);
      end
   endtask

   task automatic push_rsp(input logic [31:0] rd, input logic err);
      rsp_t r;
      r.rdata = rd;
      r.err   = err;
      exp_rsps.push_back(r);
   endtask

   task automatic push_expect(input logic [31:0] a, input logic we, input logic [1:0] sz,
                              input logic [31:0] wd, input logic [31:0] rd, input logic err);
      if (!err) push_strobes(a, we, 1 << sz, wd);
      push_rsp(err ? 32'h0 : rd, err);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50; i++) begin
         @(negedge i_clk);
         if (o_req_ready) break;
      end
      check("ready_timeout", 32'(o_req_ready), 32'd1);
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic [31:0] wd);
      i_req_valid = 1'b1;
      i_req_addr  = a;
      i_req_we    = we;
      i_req_size  = sz;
      i_req_wdata = wd;
   endtask

   task automatic do_req(input string tag, input logic [31:0] a, input logic we,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input logic [31:0] rd, input logic err);
      int n;
      wait_ready();
      push_expect(a, we, sz, wd, rd, err);
      drive(a, we, sz, wd);
      @(posedge i_clk);
      #1 i_req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         n++;
         if (o_rsp_valid) break;
      end
      check({tag, "_latency"}, 32'(n), err ? 32'd1 : 32'((1 << sz) + 1));
      @(negedge i_clk);
      check({tag, "_rsp_pulse"}, 32'(o_rsp_valid), 32'd0);
      check({tag, "_rdata_clr"}, o_rsp_rdata, 32'h0);
      check({tag, "_err_clr"}, 32'(o_rsp_err), 32'd0);
      check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) periph[i] = 8'(8'hC0 + i);
      periph[2] = 8'hBE; periph[3] = 8'hEF;
      periph[4] = 8'h11; periph[5] = 8'h22; periph[6] = 8'h33; periph[7] = 8'h44;
      i_rst = 1'b0;
      i_req_valid = 1'b0; i_req_addr = 32'h0; i_req_we = 1'b0;
      i_req_size = 2'd0; i_req_wdata = 32'h0;
      repeat (2) @(negedge i_clk);
      check("rst_ready", 32'(o_req_ready), 32'd1);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_rdata", o_rsp_rdata, 32'h0);
      check("rst_err", 32'(o_rsp_err), 32'd0);
      check("rst_mmio_addr", o_mmio_addr, 32'h0);
      check("rst_data_out", 32'(o_mmio_data_out), 32'd0);
      check("rst_we_re", 32'({o_mmio_we, o_mmio_re}), 32'd0);
      i_rst = 1'b1;

      do_req("byte_st",   32'h2000_0000, 1'b1, 2'd0, 32'h0000_00A5, 32'h0, 1'b0);
      do_req("word_ld",   32'h2000_0004, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h4433_2211, 1'b0);
      do_req("half_ld",   32'h2000_0002, 1'b0, 2'd1, 32'h0, 32'h0000_EFBE, 1'b0);
      do_req("byte_ld",   32'h2000_0005, 1'b0, 2'd0, 32'h0, 32'h0000_0022, 1'b0);
      do_req("half_st",   32'h2000_000A, 1'b1, 2'd1, 32'hFFFF_1234, 32'h0, 1'b0);
      do_req("word_st",   32'h2000_000C, 1'b1, 2'd2, 32'hCAFE_F00D, 32'h0, 1'b0);
      do_req("mis_word",  32'h2000_0001, 1'b1, 2'd2, 32'h1234_5678, 32'h0, 1'b1);
      do_req("size3",     32'h2000_0000, 1'b0, 2'd3, 32'h0, 32'h0, 1'b1);
      do_req("mis_half",  32'h2000_0003, 1'b0, 2'd1, 32'h0, 32'h0, 1'b1);
      do_req("mis_wordb", 32'h2000_0006, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1);

      // Back-to-back: valid held high, fields changed during the first transfer.
      wait_ready();
      push_expect(32'h2000_0010, 1'b1, 2'd2, 32'h8765_4321, 32'h0, 1'b0);
      drive(32'h2000_0010, 1'b1, 2'd2, 32'h8765_4321);
      @(posedge i_clk);
      #1;
      push_expect(32'h2000_0020, 1'b1, 2'd0, 32'h0000_005A, 32'h0, 1'b0);
      drive(32'h2000_0020, 1'b1, 2'd0, 32'h0000_005A);
      @(negedge i_clk);
      check("b2b_busy", 32'(o_req_ready), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (o_req_ready) break;
      end
      check("b2b_ready", 32'(o_req_ready), 32'd1);
      check("b2b_first_done", 32'(exp_rsps.size()), 32'd1);
      @(posedge i_clk);
      #1 i_req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         if (exp_rsps.size() == 0) break;
      end
      check("b2b_second_done", 32'(exp_rsps.size()), 32'd0);

      // Reset during byte 2 of a word store: no response, bus idles at once.
      wait_ready();
      push_strobes(32'h2000_0008, 1'b1, 3, 32'hDDCC_BBAA);
      drive(32'h2000_0008, 1'b1, 2'd2, 32'hDDCC_BBAA);
      @(posedge i_clk);
      #1 i_req_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      #1 i_rst = 1'b0;
      #1;
      check("abort_we", 32'(o_mmio_we), 32'd0);
      check("abort_re", 32'(o_mmio_re), 32'd0);
      check("abort_rsp", 32'(o_rsp_valid), 32'd0);
      check("abort_ready", 32'(o_req_ready), 32'd1);
      check("abort_strobes_seen", 32'(exp_strobes.size()), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      check("post_rst_ready", 32'(o_req_ready), 32'd1);
      check("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
      do_req("post_rst_st", 32'h2000_0000, 1'b1, 2'd0, 32'h0000_003C, 32'h0, 1'b0);

      repeat (3) @(negedge i_clk);
      check("strobes_drained", 32'(exp_strobes.size()), 32'd0);
      check("rsps_drained", 32'(exp_rsps.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
